wb_timeout_bridge: RTL
======================

WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the max cycles waited for downstream ack (range 1..65535).
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, meaning the read data returned on timeout.
REQ-003 SHALL have ports:
 wb_clk_i  in  1  the single clock.
 wb_rst_i  in  1  reset, synchronous, active-high.
 wbs_cyc_i/wbs_stb_i/wbs_we_i  in  1 each  upstream Wishbone classic request.
 wbs_sel_i  in  4  byte enables.
 wbs_adr_i  in  32  address.
 wbs_dat_i  in  32  write data.
 wbs_ack_o  out  1  upstream ack.
 wbs_dat_o  out  32  upstream read data.
 m_cyc_o/m_stb_o/m_we_o  out  1 each  downstream request to the peripheral mux.
 m_sel_o  out  4; m_adr_o  out  32; m_dat_o  out  32  registered request copies.
 m_ack_i  in  1; m_dat_i  in  32  downstream response.
 timeout_irq  out  1  one-cycle pulse per timeout.
 timeout_cnt  out  8  saturating timeout count.
 last_err_adr  out  32  address of the most recent timed-out access.

Function
REQ-004 SHALL implement FSM IDLE, REQ, RESP.
REQ-005 IDLE: on wbs_cyc_i&wbs_stb_i, SHALL latch adr/dat/sel/we and move to REQ; downstream request appears 1 cycle after upstream request.
REQ-006 REQ: SHALL drive m_cyc_o=m_stb_o=1 with latched fields held stable; wait counter increments each cycle from 0.
REQ-007 REQ with m_ack_i=1: SHALL latch m_dat_i into wbs_dat_o, drop m_cyc_o/m_stb_o next cycle, move to RESP.
REQ-008 REQ with counter==TIMEOUT_CYCLES-1 and m_ack_i=0: SHALL load ERR_DATA, pulse timeout_irq, increment timeout_cnt (saturating at 255), load last_err_adr, move to RESP.
REQ-009 m_ack_i and timeout in the same cycle: ack SHALL win, no timeout recorded.
REQ-010 RESP: SHALL assert wbs_ack_o for exactly one cycle, then return to IDLE; the next request is accepted no earlier than the cycle after RESP.
REQ-011 wbs_cyc_i deasserted while in REQ: SHALL abort by dropping m_cyc_o/m_stb_o next cycle and returning to IDLE with no wbs_ack_o and no timeout.
REQ-012 wbs_dat_o SHALL hold its last value outside RESP; writes return the unchanged previous value.
REQ-013 m_ack_i outside REQ SHALL be ignored.

Reset
REQ-014 On wb_rst_i=1 at a clock edge, SHALL enter IDLE and clear all outputs, latched fields, wait counter, timeout_cnt and last_err_adr to 0, including mid-transaction; no ack is issued for an aborted transfer.

Configuration
REQ-015 Macro WB_BRIDGE_STATS_EN: when defined, timeout_cnt and last_err_adr SHALL behave per REQ-008; when undefined, both SHALL be driven constant 0 and their registers omitted. timeout_irq and the timeout mechanism SHALL be present in both cases.

Structure
REQ-016 Package wb_timeout_bridge_pkg SHALL hold the FSM state encoding and the ERR_DATA default constant.
REQ-017 The wait counter SHALL be sub-module wb_timeout_counter (clear, enable, terminal-count output, width derived from TIMEOUT_CYCLES).

Verification
REQ-018 Read with slave ack 3 cycles after m_stb_o, m_dat_i=32'h12345678 -> wbs_ack_o one cycle later, wbs_dat_o=32'h12345678, timeout_irq never set.
REQ-019 TIMEOUT_CYCLES=4, slave never acks -> m_stb_o high exactly 4 cycles, wbs_dat_o=32'hDEADBEEF with wbs_ack_o, timeout_irq single pulse, timeout_cnt=1, last_err_adr=request address.
REQ-020 TIMEOUT_CYCLES=4, m_ack_i on the 4th REQ cycle -> normal response, timeout_cnt unchanged.
REQ-021 Write adr=32'h0001_0004, dat=32'hA5, sel=4'b0001 -> m_* fields match exactly and stay stable until m_ack_i; one wbs_ack_o.
REQ-022 wb_rst_i asserted on 2nd REQ cycle -> next cycle all outputs 0, FSM IDLE, no wbs_ack_o; new request afterward completes normally.
REQ-023 Without WB_BRIDGE_STATS_EN, 300 timeouts -> timeout_cnt=0 and last_err_adr=0, 300 timeout_irq pulses; with macro defined, timeout_cnt saturates at 255.

Source files
------------

// File: rtl/wb_timeout_bridge_pkg.sv
// Shared types and constants for the Wishbone timeout bridge.
package wb_timeout_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // Bits needed to count 0 .. cycles-1, never less than one bit.
   function automatic int cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-cycle counter for the bridge: counts REQ cycles from 0 and flags
// the last cycle allowed before the access is declared timed out.
module wb_timeout_counter
   import wb_timeout_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic wb_clk_i,
   input  logic wb_rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int              CNT_W  = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tc_o = (cnt_q == TC_VAL);

   // Next count: clear wins, then advance, holding once terminal is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_timeout_bridge.sv
// Wishbone classic bridge that forwards one upstream access to the
// peripheral mux and answers upstream with ERR_DATA if the peripheral
// does not ack within TIMEOUT_CYCLES.
// Build option: define WB_BRIDGE_STATS_EN to keep the timeout counter
// (timeout_cnt) and the last timed-out address (last_err_adr); otherwise
// both outputs are tied to 0.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | no access in flight, waiting for cyc&stb
//   ST_REQ  | downstream request driven, waiting for ack or timeout
//   ST_RESP | one-cycle upstream ack with read data / ERR_DATA
module wb_timeout_bridge
   import wb_timeout_bridge_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   output logic        m_we_o,
   output logic [3:0]  m_sel_o,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   input  logic        m_ack_i,
   input  logic [31:0] m_dat_i,
   output logic        timeout_irq,
   output logic [7:0]  timeout_cnt,
   output logic [31:0] last_err_adr
);

   state_e      state_q, state_d;
   logic        m_cyc_q, m_cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rdat_q, rdat_d;
   logic        ack_q, ack_d;
   logic        irq_q, irq_d;

   logic        wait_tc;
   logic        timeout_evt;

   wb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_cnt (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .clr_i    (state_q != ST_REQ),
      .en_i     (state_q == ST_REQ),
      .tc_o     (wait_tc)
   );

   // An upstream abort or a same-cycle ack both pre-empt the timeout.
   assign timeout_evt = (state_q == ST_REQ) && wbs_cyc_i && !m_ack_i && wait_tc;

   // Next-state and next-output logic for the bridge FSM.
   always_comb begin
      state_d = state_q;
      m_cyc_d = m_cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      irq_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               we_d    = wbs_we_i;
               sel_d   = wbs_sel_i;
               adr_d   = wbs_adr_i;
               wdat_d  = wbs_dat_i;
               m_cyc_d = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!wbs_cyc_i) begin
               m_cyc_d = 1'b0;
               state_d = ST_IDLE;
            end else if (m_ack_i) begin
               // Writes leave the read-data register untouched.
               if (!we_q) begin
                  rdat_d = m_dat_i;
               end
               m_cyc_d = 1'b0;
               ack_d   = 1'b1;
               state_d = ST_RESP;
            end else if (timeout_evt) begin
               // ERR_DATA is returned for reads and writes alike so software
               // reading the data bus always sees the error signature.
               rdat_d  = ERR_DATA;
               m_cyc_d = 1'b0;
               ack_d   = 1'b1;
               irq_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            m_cyc_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         m_cyc_q <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         ack_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         m_cyc_q <= m_cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         irq_q   <= irq_d;
      end
   end

   assign m_cyc_o     = m_cyc_q;
   assign m_stb_o     = m_cyc_q;
   assign m_we_o      = we_q;
   assign m_sel_o     = sel_q;
   assign m_adr_o     = adr_q;
   assign m_dat_o     = wdat_q;
   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = rdat_q;
   assign timeout_irq = irq_q;

`ifdef WB_BRIDGE_STATS_EN
   logic [7:0]  timeout_cnt_q, timeout_cnt_d;
   logic [31:0] last_err_adr_q, last_err_adr_d;

   // Saturating timeout count and address capture on each timeout.
   always_comb begin
      timeout_cnt_d  = timeout_cnt_q;
      last_err_adr_d = last_err_adr_q;
      if (timeout_evt) begin
         last_err_adr_d = adr_q;
         if (timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timeout_cnt_q  <= '0;
         last_err_adr_q <= '0;
      end else begin
         timeout_cnt_q  <= timeout_cnt_d;
         last_err_adr_q <= last_err_adr_d;
      end
   end

   assign timeout_cnt  = timeout_cnt_q;
   assign last_err_adr = last_err_adr_q;
`else
   assign timeout_cnt  = 8'd0;
   assign last_err_adr = 32'd0;
`endif

endmodule
